// File: rtl/fifo_rd_queue.sv
// Consumer-side fetch queue: first-word-fall-through FIFO with ready/valid handshakes
// and a synchronous flush for branch/exception redirect.
module fifo_rd_queue #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [DATA_SIZE-1:0]       data_i,
    input  logic                       valide,
    output logic                       ready_o,
    output logic [DATA_SIZE-1:0]       data_o,
    output logic                       valid_o,
    input  logic                       ok,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;

    always_comb begin
        ready_o = (count != CW'(DEPTH));
        valid_o = (count != '0);
        push    = valide && ready_o;
        pop     = valid_o && ok;
        data_o  = valid_o ? mem[rd_ptr] : '0;
        count_o = count;
    end

    // Full/empty come from count alone, so the pointers may wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= data_i;
    end

endmodule
